// File: rtl/inv_pkg.sv
// Shared defaults and polarity encodings for the inverting deglitch bank.
package inv_pkg;

  localparam int NCH_DEF         = 4;
  localparam int FILT_W_DEF      = 4;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic POL_INV = 1'b1;
  localparam logic POL_BUF = 1'b0;

endpackage

// File: rtl/inv_deglitch_bank_if.sv
// Control and data bundle between the soft-start control path and the deglitch bank.
interface inv_deglitch_bank_if #(
  parameter int NCH    = 4,
  parameter int FILT_W = 4
);

  logic              en;
  logic [FILT_W-1:0] filt_len;
  logic [NCH-1:0]    pol;
  logic [NCH-1:0]    i;
  logic [NCH-1:0]    o;
  logic [NCH-1:0]    chg;

  modport master (output en, filt_len, pol, i, input o, chg);
  modport slave  (input en, filt_len, pol, i, output o, chg);

endinterface

// File: rtl/inv_deglitch_ch.sv
// One channel: input synchroniser, deglitch counter, qualified level, polarity
// select and a change pulse that is suppressed on the first edge after reset.
module inv_deglitch_ch
  import inv_pkg::*;
#(
  parameter int FILT_W      = FILT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              pol_i,
  input  logic              data_i,
  output logic              data_o,
  output logic              chg_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   o_q, o_d;
  logic                   chg_q, chg_d;
  logic                   started_q;
  logic                   syncOut;
  logic [FILT_W:0]        effLen;
  logic [FILT_W:0]        cntInc;

  assign syncOut = sync_q[SYNC_STAGES-1];

  // A zero length is treated as one so a single mismatching sample qualifies.
  always_comb begin
    effLen   = (filt_len_i == '0) ? {{FILT_W{1'b0}}, 1'b1} : {1'b0, filt_len_i};
    cntInc   = {1'b0, cnt_q} + {{FILT_W{1'b0}}, 1'b1};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (syncOut == stable_q) begin
      cnt_d = '0;
    end else if (cntInc >= effLen) begin
      stable_d = syncOut;
      cnt_d    = '0;
    end else if (cnt_q != {FILT_W{1'b1}}) begin
      cnt_d = cntInc[FILT_W-1:0];
    end
  end

  // Output follows the previous qualified level; the first edge always loads it.
  always_comb begin
    o_d = o_q;
    if (en_i || !started_q) begin
      o_d = (pol_i == POL_INV) ? ~stable_q : stable_q;
    end
    chg_d = started_q && (o_d != o_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= '0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      o_q       <= 1'b1;
      chg_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], data_i};
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      chg_q     <= chg_d;
      started_q <= 1'b1;
    end
  end

  assign data_o = o_q;
  assign chg_o  = chg_q;

endmodule

// File: rtl/inv_deglitch_bank.sv
// NCH independent deglitching inverter/buffer channels sharing clock, reset,
// enable and filter length; supply pins exist only for power-aware netlists.
module inv_deglitch_bank
  import inv_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic                clk,
  input logic                rstn,
  input logic                CELV,
  input logic                CELG,
  input logic                SUB,
  inv_deglitch_bank_if.slave bus
);

  logic [NCH-1:0] oVec;
  logic [NCH-1:0] chgVec;
  logic           unusedSupply;

  assign unusedSupply = ^{CELV, CELG, SUB};

  for (genvar ch = 0; ch < NCH; ch++) begin : gCh
    inv_deglitch_ch #(
      .FILT_W      (FILT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) uCh (
      .clk        (clk),
      .rstn       (rstn),
      .en_i       (bus.en),
      .filt_len_i (bus.filt_len),
      .pol_i      (bus.pol[ch]),
      .data_i     (bus.i[ch]),
      .data_o     (oVec[ch]),
      .chg_o      (chgVec[ch])
    );
  end

  assign bus.o   = oVec;
  assign bus.chg = chgVec;

endmodule

// File: tb/tb_inv_deglitch_bank.sv
// Bench for inv_deglitch_bank: directed vector table, a reset-mid-count sequence
// and randomized traffic checked every cycle against a queue-based model.
module tb_inv_deglitch_bank;

  localparam int NCH  = 4;
  localparam int FW   = 4;
  localparam int SYNC = 2;

  typedef struct {
    logic          rstn;
    logic          en;
    logic [FW-1:0] filt;
    logic [3:0]    pol;
    logic [3:0]    i;
    logic [3:0]    expO;
    logic [3:0]    expChg;
  } vec_t;

  logic clk;
  logic rstn;
  int   testsRun;
  int   testsFailed;
  bit   modelOn;
  vec_t vecs[$];

  inv_deglitch_bank_if #(.NCH(NCH), .FILT_W(FW)) bus ();

  inv_deglitch_bank #(.NCH(NCH), .FILT_W(FW), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .CELV (1'b1),
    .CELG (1'b0),
    .SUB  (1'b0),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: s is the input seen SYNC edges ago; a level is adopted once
  // eff consecutive enabled samples disagree with it; o lags stable by one edge.
  logic [3:0] histQ[$];
  int         pend[NCH];
  logic [3:0] mStable, mO, mChg;
  bit         mStarted;

  always @(posedge clk or negedge rstn) begin : modelBlk
    logic [3:0] s, newO;
    int eff;
    if (!rstn) begin
      histQ.delete();
      pend     = '{default: 0};
      mStable  = '0;
      mO       = '1;
      mChg     = '0;
      mStarted = 1'b0;
    end else begin
      s = (histQ.size() >= SYNC) ? histQ[histQ.size()-SYNC] : 4'b0;
      histQ.push_back(bus.i);
      if (histQ.size() > SYNC) void'(histQ.pop_front());
      newO = mO;
      if (bus.en || !mStarted) newO = bus.pol ^ mStable;
      mChg     = mStarted ? (newO ^ mO) : 4'b0;
      mO       = newO;
      mStarted = 1'b1;
      eff = (bus.filt_len == 0) ? 1 : int'(bus.filt_len);
      for (int ch = 0; ch < NCH; ch++) begin
        if (!bus.en || s[ch] == mStable[ch]) begin
          pend[ch] = 0;
        end else begin
          pend[ch]++;
          if (pend[ch] >= eff) begin
            mStable[ch] = s[ch];
            pend[ch]    = 0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (modelOn) begin
      testsRun++;
      if ({bus.o, bus.chg} !== {mO, mChg}) begin
        testsFailed++;
        $display("[TB] FAIL model t=%0t o=%b chg=%b expected o=%b chg=%b",
                 $time, bus.o, bus.chg, mO, mChg);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic [FW-1:0] f,
                               input logic [3:0] p, input logic [3:0] iv);
    rstn         = r;
    bus.en       = e;
    bus.filt_len = f;
    bus.pol      = p;
    bus.i        = iv;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expO, input logic [3:0] expChg);
    testsRun++;
    if (bus.o !== expO || bus.chg !== expChg) begin
      testsFailed++;
      $display("[TB] FAIL %s o=%b chg=%b expected o=%b chg=%b", name, bus.o, bus.chg, expO, expChg);
    end
  endtask

  function automatic vec_t mk(logic r, logic e, logic [FW-1:0] f, logic [3:0] p,
                              logic [3:0] iv, logic [3:0] eo, logic [3:0] ec);
    vec_t v;
    v.rstn = r; v.en = e; v.filt = f; v.pol = p; v.i = iv; v.expO = eo; v.expChg = ec;
    return v;
  endfunction

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    modelOn     = 1'b1;
    rstn        = 1'b0;

    // Reset, then release with inverting polarity on a held 1010 input.
    vecs.push_back(mk(0, 1, 1, 4'hF, 4'hA, 4'hF, 4'h0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 1, 1, 4'hF, 4'hA, 4'hF, 4'h0));
    vecs.push_back(mk(1, 1, 1, 4'hF, 4'hA, 4'h5, 4'hA));
    vecs.push_back(mk(1, 1, 1, 4'hF, 4'hA, 4'h5, 4'h0));
    // Latency: filt_len=3, i[0] rises, o[0] falls on the sixth edge.
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 1, 3, 4'hF, 4'hB, 4'h5, 4'h0));
    vecs.push_back(mk(1, 1, 3, 4'hF, 4'hB, 4'h4, 4'h1));
    vecs.push_back(mk(1, 1, 3, 4'hF, 4'hB, 4'h4, 4'h0));
    // Drop i[1] and let it qualify, then a two-cycle high glitch must be ignored.
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 1, 3, 4'hF, 4'h9, 4'h4, 4'h0));
    vecs.push_back(mk(1, 1, 3, 4'hF, 4'h9, 4'h6, 4'h2));
    vecs.push_back(mk(1, 1, 3, 4'hF, 4'h9, 4'h6, 4'h0));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1, 1, 3, 4'hF, 4'hB, 4'h6, 4'h0));
    for (int k = 0; k < 6; k++) vecs.push_back(mk(1, 1, 3, 4'hF, 4'h9, 4'h6, 4'h0));
    // Bypass length and polarity flips on channel 2.
    vecs.push_back(mk(1, 1, 0, 4'hB, 4'h9, 4'h2, 4'h4));
    vecs.push_back(mk(1, 1, 0, 4'hB, 4'h9, 4'h2, 4'h0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 1, 0, 4'hB, 4'hD, 4'h2, 4'h0));
    vecs.push_back(mk(1, 1, 0, 4'hB, 4'hD, 4'h6, 4'h4));
    vecs.push_back(mk(1, 1, 0, 4'hF, 4'hD, 4'h2, 4'h4));
    vecs.push_back(mk(1, 1, 0, 4'hF, 4'hD, 4'h2, 4'h0));
    // Freeze with all inputs toggled, then re-enable with filt_len=2.
    for (int k = 0; k < 6; k++) vecs.push_back(mk(1, 0, 2, 4'hF, 4'h2, 4'h2, 4'h0));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1, 1, 2, 4'hF, 4'h2, 4'h2, 4'h0));
    vecs.push_back(mk(1, 1, 2, 4'hF, 4'h2, 4'hD, 4'hF));
    vecs.push_back(mk(1, 1, 2, 4'hF, 4'h2, 4'hD, 4'h0));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rstn, vecs[k].en, vecs[k].filt, vecs[k].pol, vecs[k].i);
      checkOutput($sformatf("vec%0d", k), vecs[k].expO, vecs[k].expChg);
    end

    // Reset while channel 3 is seven counts into a 15-cycle qualification.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, 1, 15, 4'hF, 4'hA);
      checkOutput($sformatf("midcount%0d", k), 4'hD, 4'h0);
    end
    applyStimulus(0, 1, 15, 4'hF, 4'hA);
    checkOutput("resetMid", 4'hF, 4'h0);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1, 1, 15, 4'hF, 4'hA);
      checkOutput($sformatf("requal%0d", k), 4'hF, 4'h0);
    end
    applyStimulus(1, 1, 15, 4'hF, 4'hA);
    checkOutput("requalDone", 4'h5, 4'hA);

    // Randomized traffic with sticky inputs so some transitions qualify.
    begin
      logic          rr, ee;
      logic [FW-1:0] ff;
      logic [3:0]    pp, ii;
      ff = 2; pp = 4'hF; ii = 4'h0;
      for (int k = 0; k < 600; k++) begin
        rr = ($urandom_range(0, 99) != 0);
        ee = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 9) == 0) ff = FW'($urandom_range(0, 4));
        if ($urandom_range(0, 19) == 0) pp = 4'($urandom);
        for (int b = 0; b < NCH; b++)
          if ($urandom_range(0, 5) == 0) ii[b] = ~ii[b];
        applyStimulus(rr, ee, ff, pp, ii);
      end
    end

    modelOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
